// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronised, glitch-filtered pins, 11-bit frame deframer with
// parity/stop/timeout checking, and a first-word-fall-through scan-code FIFO.
module ps2_rx_fifo #(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned FILTER_LEN   = 8,
    parameter int unsigned TIMEOUT_CYC  = 50000,
    parameter int unsigned CHECK_PARITY = 1,
    localparam int unsigned AW = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    input  logic          read,
    input  logic          err_clr,
    output logic [7:0]    scan_code,
    output logic          scan_ready,
    output logic [AW:0]   fifo_count,
    output logic          parity_err,
    output logic          frame_err,
    output logic          overflow
);
    localparam int unsigned FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // index 0 = ps2_clk path, index 1 = ps2_data path
    logic [1:0][1:0]    sync_q;
    logic [1:0]         filt_q, filt_d;
    logic [1:0][FW-1:0] fcnt_q, fcnt_d;
    logic               clk_prev_q;
    logic               fall, din;

    state_t             state_q, state_d;
    logic [7:0]         shreg_q, shreg_d;
    logic [2:0]         bitcnt_q, bitcnt_d;
    logic               par_q, par_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic               push_q, push_d;
    logic               perr_set, ferr_set;

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        count_q, count_d;
    logic               empty, full, pop, wr, ovf_set;
    logic               perr_q, ferr_q, ovf_q;

    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        for (int unsigned i = 0; i < 2; i++) begin
            if (sync_q[i][1] == filt_q[i]) begin
                fcnt_d[i] = '0;
            end else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
                filt_d[i] = ~filt_q[i];
                fcnt_d[i] = '0;
            end else begin
                fcnt_d[i] = fcnt_q[i] + 1'b1;
            end
        end
    end

    assign fall = clk_prev_q & ~filt_q[0];
    assign din  = filt_q[1];

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        par_d    = par_q;
        tcnt_d   = '0;
        push_d   = 1'b0;
        perr_set = 1'b0;
        ferr_set = 1'b0;
        if (state_q != S_IDLE && !fall) begin
            tcnt_d = tcnt_q + 1'b1;
            if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d  = S_IDLE;
                tcnt_d   = '0;
                ferr_set = 1'b1;
            end
        end
        if (fall) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!din) begin
                        state_d  = S_DATA;
                        bitcnt_d = '0;
                    end
                end
                S_DATA: begin
                    shreg_d  = {din, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = din;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    if (!din)                                           ferr_set = 1'b1;
                    else if (CHECK_PARITY != 0 && !(^{shreg_q, par_q})) perr_set = 1'b1;
                    else                                                push_d   = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // shreg_q is stable in IDLE until the next frame's first data bit, so it is the push data
    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign pop     = read & ~empty;
    assign wr      = push_q & (~full | pop);
    assign ovf_set = push_q & full & ~pop;
    assign count_d = count_q + (AW + 1)'(wr) - (AW + 1)'(pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '1;
            filt_q     <= '1;
            fcnt_q     <= '0;
            clk_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            par_q      <= 1'b0;
            tcnt_q     <= '0;
            push_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[1][0], ps2_data, sync_q[0][0], ps2_clk};
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            clk_prev_q <= filt_q[0];
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            par_q      <= par_d;
            tcnt_q     <= tcnt_d;
            push_q     <= push_d;
            if (wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            perr_q     <= perr_set | (perr_q & ~err_clr);
            ferr_q     <= ferr_set | (ferr_q & ~err_clr);
            ovf_q      <= ovf_set  | (ovf_q  & ~err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= shreg_q;
    end

    assign scan_ready = ~empty;
    assign scan_code  = empty ? '0 : mem_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frame table plus timeout, overflow, glitch and reset sequences.
module tb_ps2_rx_fifo;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned FLEN  = 8;
    localparam int unsigned TOUT  = 300;
    localparam int unsigned HALF  = 20;

    logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic read = 1'b0, read2 = 1'b0, err_clr = 1'b0;
    logic [7:0] code, code2;
    logic       rdy, rdy2, pe, pe2, fe, fe2, ov, ov2;
    logic [3:0] cnt, cnt2;

    int nvec = 0;
    int nerr = 0;

    ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYC(TOUT), .CHECK_PARITY(1)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .read(read),
        .err_clr(err_clr), .scan_code(code), .scan_ready(rdy), .fifo_count(cnt),
        .parity_err(pe), .frame_err(fe), .overflow(ov));

    ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYC(TOUT), .CHECK_PARITY(0)) dut2 (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .read(read2),
        .err_clr(err_clr), .scan_code(code2), .scan_ready(rdy2), .fifo_count(cnt2),
        .parity_err(pe2), .frame_err(fe2), .overflow(ov2));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] code;
        logic [3:0] cnt;
        logic       pe;
        logic       fe;
        logic [3:0] cnt2;
    } vec_t;
    vec_t vecs[4];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // bits[0] is sent first; n bits are clocked out
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            tick(HALF);
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bits({stop, par, d, 1'b0}, 11);
        ps2_data = 1'b1;
        tick(HALF);
    endtask

    task automatic send_good(input logic [7:0] d);
        send_frame(d, ~^d, 1'b1);
    endtask

    task automatic pulse_read();
        read = 1'b1;
        tick(1);
        read = 1'b0;
        tick(1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rdy"},  rdy,  1'b0);
        chk({tag, "_code"}, code, 8'h00);
        chk({tag, "_cnt"},  cnt,  4'd0);
        chk({tag, "_err"},  {pe, fe, ov}, 3'b000);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask

    initial begin
        vecs[0] = '{data: 8'h1C, par: 1'b0, stop: 1'b1, code: 8'h1C, cnt: 4'd1, pe: 1'b0, fe: 1'b0, cnt2: 4'd1};
        vecs[1] = '{data: 8'h1C, par: 1'b1, stop: 1'b1, code: 8'h1C, cnt: 4'd1, pe: 1'b1, fe: 1'b0, cnt2: 4'd2};
        vecs[2] = '{data: 8'h33, par: 1'b1, stop: 1'b0, code: 8'h1C, cnt: 4'd1, pe: 1'b1, fe: 1'b1, cnt2: 4'd2};
        vecs[3] = '{data: 8'hF0, par: 1'b1, stop: 1'b1, code: 8'h1C, cnt: 4'd2, pe: 1'b1, fe: 1'b1, cnt2: 4'd3};

        tick(3);
        check_zero("reset");
        do_reset();

        for (int i = 0; i < 4; i++) begin
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
            chk($sformatf("v%0d_rdy", i),  rdy,  1'b1);
            chk($sformatf("v%0d_code", i), code, vecs[i].code);
            chk($sformatf("v%0d_cnt", i),  cnt,  vecs[i].cnt);
            chk($sformatf("v%0d_pe", i),   pe,   vecs[i].pe);
            chk($sformatf("v%0d_fe", i),   fe,   vecs[i].fe);
            chk($sformatf("v%0d_cnt2", i), cnt2, vecs[i].cnt2);
            chk($sformatf("v%0d_pe2", i),  pe2,  1'b0);
        end

        pulse_read();
        chk("pop1_code", code, 8'hF0);
        chk("pop1_cnt",  cnt,  4'd1);
        pulse_read();
        chk("pop2_cnt", cnt, 4'd0);
        chk("pop2_rdy", rdy, 1'b0);
        pulse_read();
        chk("pop_empty_cnt", cnt, 4'd0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(1);
        chk("clr_pe", pe, 1'b0);
        chk("clr_fe", fe, 1'b0);

        // timeout after start + 4 data bits
        do_reset();
        send_bits(11'b000_0101_0110, 5);
        ps2_data = 1'b1;
        tick(100);
        chk("tout_early_fe", fe, 1'b0);
        tick(250);
        chk("tout_fe", fe, 1'b1);
        send_good(8'h5A);
        chk("tout_next_code", code, 8'h5A);
        chk("tout_next_cnt",  cnt,  4'd1);
        chk("tout_next_pe",   pe,   1'b0);

        // fill beyond depth
        do_reset();
        for (int i = 1; i <= 8; i++) send_good(8'(i));
        chk("full_cnt", cnt, 4'd8);
        chk("full_ov",  ov,  1'b0);
        send_good(8'h09);
        chk("ovf_cnt", cnt, 4'd8);
        chk("ovf_ov",  ov,  1'b1);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain%0d_code", i), code, 32'(i));
            pulse_read();
        end
        chk("drain_cnt", cnt, 4'd0);
        chk("drain_ov",  ov,  1'b1);

        // short glitch on ps2_clk must not start a frame
        do_reset();
        ps2_data = 1'b0;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(FLEN - 2);
        ps2_clk = 1'b1;
        tick(HALF);
        ps2_data = 1'b1;
        tick(HALF);
        send_good(8'h1C);
        chk("glitch_code", code, 8'h1C);
        chk("glitch_cnt",  cnt,  4'd1);
        chk("glitch_fe",   fe,   1'b0);

        // reset mid-frame
        send_bits(11'b000_0011_0010, 4);
        reset = 1'b1;
        #1;
        check_zero("midrst");
        tick(2);
        reset = 1'b0;
        ps2_data = 1'b1;
        tick(2);
        send_good(8'h5A);
        chk("midrst_next_code", code, 8'h5A);
        chk("midrst_next_cnt",  cnt,  4'd1);
        chk("midrst_next_fe",   fe,   1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
